// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bw_in, with borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bw_in,
   output logic d,
   output logic bw_out
);

   assign d      = x ^ y ^ bw_in;
   assign bw_out = (~x & y) | (~(x ^ y) & bw_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, diff = a - b - b_in over WIDTH cycles.
// Optional signed-overflow output ovf when SERIAL_SUB_OVF_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start, last result held on diff/b_out
// RUN    | one bit per cycle through the full-subtractor cell
// DONE   | result valid, done pulse for one cycle
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             busy,
   output logic             done
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state_q;
   logic [WIDTH-1:0]   a_sr_q;
   logic [WIDTH-1:0]   b_sr_q;
   logic [WIDTH-1:0]   res_sr_q;
   logic [WIDTH-1:0]   diff_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               bw_q;
   logic               b_out_q;
   logic               busy_q;
   logic               done_q;
`ifdef SERIAL_SUB_OVF_EN
   logic               ovf_q;
`endif

   logic               d_bit;
   logic               bw_d;
   logic [WIDTH-1:0]   res_d;

   full_subtractor u_fs (
      .x      (a_sr_q[0]),
      .y      (b_sr_q[0]),
      .bw_in  (bw_q),
      .d      (d_bit),
      .bw_out (bw_d)
   );

   // New bit enters at the MSB; after WIDTH steps the LSB-first stream is aligned.
   assign res_d = WIDTH'({d_bit, res_sr_q} >> 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         bw_q     <= 1'b0;
         b_out_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_sr_q   <= a;
                  b_sr_q   <= b;
                  bw_q     <= b_in;
                  cnt_q    <= '0;
                  res_sr_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               a_sr_q   <= a_sr_q >> 1;
               b_sr_q   <= b_sr_q >> 1;
               res_sr_q <= res_d;
               bw_q     <= bw_d;
               cnt_q    <= cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  diff_q  <= res_d;
                  b_out_q <= bw_d;
`ifdef SERIAL_SUB_OVF_EN
                  // bw_q here is the borrow into the MSB
                  ovf_q   <= bw_q ^ bw_d;
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign diff  = diff_q;
   assign b_out = b_out_q;
   assign busy  = busy_q;
   assign done  = done_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule
